// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the seven-segment display path.
//   seg7_state_e : arbiter FSM state (ST_IDLE shows background, ST_SHOW shows message)
//   SEG7_DATA_W  : width of the packed 8 x 4-bit digit data bus
//   SEG7_DIGITS  : number of digits (one point/LES bit per digit)
package seg7_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } seg7_state_e;

    localparam int SEG7_DATA_W = 32;
    localparam int SEG7_DIGITS = 8;

endpackage

// File: rtl/seg7_timebase.sv
// seg7_timebase: free-running BLINK_DIV-bit up-counter that wraps to 0.
// Ports:
//   i_clk, i_rst : system clock, asynchronous active-high reset
//   o_scan [1:0] : digit-scan index, counter bits [SCAN_DIV-1:SCAN_DIV-2]
//   o_blink      : blink clock, counter bit [BLINK_DIV-1] (50% duty)
module seg7_timebase #(
    parameter int SCAN_DIV  = 17,
    parameter int BLINK_DIV = 25
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic [1:0] o_scan,
    output logic       o_blink
);

    logic [BLINK_DIV-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_cnt <= '0;
        else       r_cnt <= r_cnt + 1'b1;
    end

    assign o_scan  = r_cnt[SCAN_DIV-1:SCAN_DIV-2];
    assign o_blink = r_cnt[BLINK_DIV-1];

endmodule

// File: rtl/seg7_display_arbiter.sv
// seg7_display_arbiter: shares the 8-digit seven-segment display between the
// background source (base_*) and a transient message requester (msg_*), and
// provides the digit-scan index and blink clock for seg7_controller.
// Ports:
//   clk, rst                       : system clock, asynchronous active-high reset
//   base_data/base_point/base_les  : background content, shown while idle
//   msg_req                        : level request, every high cycle is one accept
//   msg_data/msg_point/msg_les     : message content, latched on accept
//   msg_cancel                     : ends the current message early (request wins)
//   msg_ack                        : one-cycle pulse per accept
//   msg_busy                       : message owns the display
//   data/point/les                 : registered display content
//   clkScan, clkBlink              : timebase slices
// Build option: define SEG7_MSG_BLINK_EN to force les to 8'hFF during the last
// HOLD_CYCLES/4 cycles of a message as an expiry warning.
module seg7_display_arbiter
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV    = 17,
    parameter int BLINK_DIV   = 25,
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int HOLD_W      = 27
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SEG7_DATA_W-1:0] base_data,
    input  logic [SEG7_DIGITS-1:0] base_point,
    input  logic [SEG7_DIGITS-1:0] base_les,
    input  logic                   msg_req,
    input  logic [SEG7_DATA_W-1:0] msg_data,
    input  logic [SEG7_DIGITS-1:0] msg_point,
    input  logic [SEG7_DIGITS-1:0] msg_les,
    input  logic                   msg_cancel,
    output logic                   msg_ack,
    output logic                   msg_busy,
    output logic [SEG7_DATA_W-1:0] data,
    output logic [SEG7_DIGITS-1:0] point,
    output logic [SEG7_DIGITS-1:0] les,
    output logic [1:0]             clkScan,
    output logic                   clkBlink
);

    localparam logic [0:0] S_IDLE = 1'(ST_IDLE);
    localparam logic [0:0] S_SHOW = 1'(ST_SHOW);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    logic [0:0]             r_state;
    logic [HOLD_W-1:0]      r_hold_cnt;
    logic [SEG7_DATA_W-1:0] r_msg_data;
    logic [SEG7_DIGITS-1:0] r_msg_point;
    logic [SEG7_DIGITS-1:0] r_msg_les;
    logic                   r_ack;
    logic [SEG7_DATA_W-1:0] r_data;
    logic [SEG7_DIGITS-1:0] r_point;
    logic [SEG7_DIGITS-1:0] r_les;
    logic [SEG7_DIGITS-1:0] w_msg_les;

`ifdef SEG7_MSG_BLINK_EN
    localparam logic [HOLD_W-1:0] WARN_LIM = HOLD_W'(HOLD_CYCLES / 4);
    // hold_cnt is reloaded on every accept, so a retrigger leaves the
    // warning window until the new hold time runs down into it again.
    assign w_msg_les = (r_hold_cnt < WARN_LIM) ? {SEG7_DIGITS{1'b1}} : r_msg_les;
`else
    assign w_msg_les = r_msg_les;
`endif

    // FSM, hold counter and message latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hold_cnt  <= '0;
            r_msg_data  <= '0;
            r_msg_point <= '0;
            r_msg_les   <= '0;
            r_ack       <= 1'b0;
        end else begin
            r_ack <= msg_req;
            if (msg_req) begin
                // accept (also a retrigger in SHOW); beats a same-cycle cancel
                r_msg_data  <= msg_data;
                r_msg_point <= msg_point;
                r_msg_les   <= msg_les;
                r_hold_cnt  <= HOLD_LOAD;
                r_state     <= S_SHOW;
            end else if (r_state == S_SHOW) begin
                if (msg_cancel || r_hold_cnt == '0) r_state <= S_IDLE;
                else                                r_hold_cnt <= r_hold_cnt - 1'b1;
            end
        end
    end

    // Output registers follow the registered state, so a message reaches
    // data one edge after its accept and stays for exactly HOLD_CYCLES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_point <= '0;
            r_les   <= '0;
        end else if (r_state == S_SHOW) begin
            r_data  <= r_msg_data;
            r_point <= r_msg_point;
            r_les   <= w_msg_les;
        end else begin
            r_data  <= base_data;
            r_point <= base_point;
            r_les   <= base_les;
        end
    end

    assign msg_ack  = r_ack;
    assign msg_busy = (r_state == S_SHOW);
    assign data     = r_data;
    assign point    = r_point;
    assign les      = r_les;

    seg7_timebase #(
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) u_timebase (
        .i_clk   (clk),
        .i_rst   (rst),
        .o_scan  (clkScan),
        .o_blink (clkBlink)
    );

endmodule
